// File: rtl/pokemon_tick_master.sv
// Avalon-MM initiator that programs the SoC interval timer, runs it continuously and turns each timer IRQ into a tick pulse.
// Optional snapshot-read feature is enabled by defining POKEMON_TICK_SNAPSHOT_EN.
module pokemon_tick_master #(
    parameter int unsigned DEF_PERIOD = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_start,
    input  logic        cfg_stop,
    input  logic [31:0] cfg_period,
`ifdef POKEMON_TICK_SNAPSHOT_EN
    input  logic        cfg_snap,
    output logic [31:0] snap_value,
    output logic        snap_valid,
`endif
    output logic [3:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [15:0] m_writedata,
    input  logic [15:0] m_readdata,
    input  logic        timer_irq,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, WR_P0, WR_P1, WR_P2, WR_P3, WR_CTRL, RUN, CLR, WR_STOP
`ifdef POKEMON_TICK_SNAPSHOT_EN
        , SNAP_W, SNAP_R0, SNAP_R1, SNAP_R2
`endif
    } state_t;

    typedef struct packed {
        logic [3:0]  addr;
        logic        cs;
        logic        wr_n;
        logic [15:0] data;
    } bus_t;

    localparam bus_t BUS_IDLE = '{addr: 4'd0, cs: 1'b0, wr_n: 1'b1, data: 16'h0000};

    function automatic bus_t bus_wr(input logic [3:0] a, input logic [15:0] d);
        return '{addr: a, cs: 1'b1, wr_n: 1'b0, data: d};
    endfunction

`ifdef POKEMON_TICK_SNAPSHOT_EN
    function automatic bus_t bus_rd(input logic [3:0] a);
        return '{addr: a, cs: 1'b1, wr_n: 1'b1, data: 16'h0000};
    endfunction

    logic [15:0] snap_lo;
`else
    logic unused_readdata;
    assign unused_readdata = ^m_readdata;
`endif

    state_t      state;
    bus_t        bus;
    logic [31:0] load_q;
    logic        stop_pending;
    logic [31:0] load_val;

    // Timer load value: zero period selects the default, and the result never drops below 1.
    always_comb begin
        // NOTE: assign a default before any conditional override so no path leaves the signal unassigned (no latch).
        load_val = ((cfg_period == 32'd0) ? 32'(DEF_PERIOD) : cfg_period) - 32'd1;
        if (load_val == 32'd0)
            load_val = 32'd1;
    end

    assign m_address    = bus.addr;
    assign m_chipselect = bus.cs;
    assign m_write_n    = bus.wr_n;
    assign m_writedata  = bus.data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bus          <= BUS_IDLE;
            tick         <= 1'b0;
            tick_count   <= 16'h0000;
            busy         <= 1'b0;
            load_q       <= 32'd0;
            stop_pending <= 1'b0;
`ifdef POKEMON_TICK_SNAPSHOT_EN
            snap_lo      <= 16'h0000;
            snap_value   <= 32'd0;
            snap_valid   <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments; later assignments in this block override these defaults.
            bus  <= BUS_IDLE;
            tick <= 1'b0;
`ifdef POKEMON_TICK_SNAPSHOT_EN
            snap_valid <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        load_q       <= load_val;
                        bus          <= bus_wr(4'd2, load_val[15:0]);
                        busy         <= 1'b1;
                        stop_pending <= 1'b0;
                        state        <= WR_P0;
                    end
                end
                WR_P0: begin
                    bus   <= bus_wr(4'd3, load_q[31:16]);
                    state <= WR_P1;
                end
                WR_P1: begin
                    bus   <= bus_wr(4'd4, 16'h0000);
                    state <= WR_P2;
                end
                WR_P2: begin
                    bus   <= bus_wr(4'd5, 16'h0000);
                    state <= WR_P3;
                end
                WR_P3: begin
                    bus   <= bus_wr(4'd1, 16'h0007);
                    state <= WR_CTRL;
                end
                WR_CTRL: state <= RUN;
                RUN: begin
                    if (timer_irq) begin
                        // A stop arriving with the IRQ waits until the status clear is done.
                        bus        <= bus_wr(4'd0, 16'h0000);
                        tick       <= 1'b1;
                        tick_count <= tick_count + 16'd1;
                        if (cfg_stop)
                            stop_pending <= 1'b1;
                        state      <= CLR;
                    end else if (cfg_stop || stop_pending) begin
                        bus          <= bus_wr(4'd1, 16'h0008);
                        stop_pending <= 1'b0;
                        state        <= WR_STOP;
`ifdef POKEMON_TICK_SNAPSHOT_EN
                    end else if (cfg_snap) begin
                        bus   <= bus_wr(4'd6, 16'h0000);
                        state <= SNAP_W;
`endif
                    end
                end
                CLR: begin
                    if (cfg_stop)
                        stop_pending <= 1'b1;
                    state <= RUN;
                end
                WR_STOP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
`ifdef POKEMON_TICK_SNAPSHOT_EN
                SNAP_W: begin
                    bus   <= bus_rd(4'd6);
                    state <= SNAP_R0;
                end
                SNAP_R0: begin
                    bus   <= bus_rd(4'd7);
                    state <= SNAP_R1;
                end
                // Read data lags the address by one cycle, so each half is captured a state later.
                SNAP_R1: begin
                    snap_lo <= m_readdata;
                    state   <= SNAP_R2;
                end
                SNAP_R2: begin
                    snap_value <= {m_readdata, snap_lo};
                    snap_valid <= 1'b1;
                    state      <= RUN;
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pokemon_tick_master.sv
// Self-checking bench for pokemon_tick_master: bus access tables, IRQ servicing, stop handling, count wrap and optional snapshot.
// Define POKEMON_TICK_SNAPSHOT_EN for both bench and RTL to exercise the snapshot path.
module tb_pokemon_tick_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start, cfg_stop;
    logic [31:0] cfg_period;
    logic [3:0]  m_address;
    logic        m_chipselect, m_write_n;
    logic [15:0] m_writedata, m_readdata;
    logic        timer_irq, tick, busy;
    logic [15:0] tick_count;
`ifdef POKEMON_TICK_SNAPSHOT_EN
    logic        cfg_snap, snap_valid;
    logic [31:0] snap_value;
    logic [15:0] rd_val6, rd_val7;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_count;

    pokemon_tick_master #(.DEF_PERIOD(50000)) dut (
        .clk(clk), .reset(reset),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_period(cfg_period),
`ifdef POKEMON_TICK_SNAPSHOT_EN
        .cfg_snap(cfg_snap), .snap_value(snap_value), .snap_valid(snap_valid),
`endif
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .m_readdata(m_readdata),
        .timer_irq(timer_irq), .tick(tick), .tick_count(tick_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] period;
        logic [15:0] lo;
        logic [15:0] hi;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packed bus view {cs, write_n, addr, data}.
    task automatic check_bus(input string name, input logic cs, input logic wn,
                             input logic [3:0] a, input logic [15:0] d);
        check(name, 32'({m_chipselect, m_write_n, m_address, m_writedata}), 32'({cs, wn, a, d}));
    endtask

    // Timer model: status write clears the IRQ at the end of that cycle; reads answer one cycle later.
    task automatic step();
        logic       was_clr, was_rd;
        logic [3:0] ra;
        was_clr = m_chipselect && !m_write_n && (m_address == 4'd0);
        was_rd  = m_chipselect && m_write_n;
        ra      = m_address;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        if (was_clr)
            timer_irq = 1'b0;
`ifdef POKEMON_TICK_SNAPSHOT_EN
        cfg_snap   = 1'b0;
        m_readdata = !was_rd ? 16'h0000 : (ra == 4'd6) ? rd_val6 : (ra == 4'd7) ? rd_val7 : 16'h0000;
`else
        m_readdata = (was_rd && ra == 4'd6) ? 16'h5A5A : 16'h0000;
`endif
    endtask

    function automatic logic [31:0] exp_load(input logic [31:0] p);
        longint v;
        v = (p == 32'd0) ? 64'd50000 : longint'(p);
        v = v - 1;
        if (v < 1)
            v = 1;
        return 32'(v);
    endfunction

    // Start the timer and check the five programming writes; noise injects dropped start/stop pulses.
    task automatic program_timer(input string tag, input logic [31:0] p,
                                 input logic [15:0] lo, input logic [15:0] hi, input bit noise);
        cfg_period = p;
        cfg_start  = 1'b1;
        step();
        cfg_period = ~p;
        check_bus({tag, " wr a2"}, 1'b1, 1'b0, 4'd2, lo);
        check({tag, " busy"}, 32'(busy), 32'd1);
        if (noise) begin
            cfg_start = 1'b1;
            cfg_stop  = 1'b1;
        end
        step();
        check_bus({tag, " wr a3"}, 1'b1, 1'b0, 4'd3, hi);
        if (noise) cfg_stop = 1'b1;
        step();
        check_bus({tag, " wr a4"}, 1'b1, 1'b0, 4'd4, 16'h0000);
        step();
        check_bus({tag, " wr a5"}, 1'b1, 1'b0, 4'd5, 16'h0000);
        step();
        check_bus({tag, " wr a1 ctrl"}, 1'b1, 1'b0, 4'd1, 16'h0007);
        check({tag, " busy ctrl"}, 32'(busy), 32'd1);
        step();
        check_bus({tag, " run idle"}, 1'b0, 1'b1, 4'd0, 16'h0000);
        check({tag, " busy run"}, 32'(busy), 32'd1);
    endtask

    task automatic stop_timer(input string tag);
        cfg_stop = 1'b1;
        step();
        check_bus({tag, " wr stop"}, 1'b1, 1'b0, 4'd1, 16'h0008);
        step();
        check_bus({tag, " idle bus"}, 1'b0, 1'b1, 4'd0, 16'h0000);
        check({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    task automatic service_irq(input string tag);
        timer_irq = 1'b1;
        step();
        model_count = model_count + 16'd1;
        check_bus({tag, " clr"}, 1'b1, 1'b0, 4'd0, 16'h0000);
        check({tag, " tick"}, 32'(tick), 32'd1);
        check({tag, " count"}, 32'(tick_count), 32'(model_count));
        step();
        check({tag, " tick low"}, 32'(tick), 32'd0);
        check_bus({tag, " back run"}, 1'b0, 1'b1, 4'd0, 16'h0000);
    endtask

    initial begin
        vecs[0] = '{period: 32'd50000,      lo: 16'hC34F, hi: 16'h0000};
        vecs[1] = '{period: 32'd1,          lo: 16'h0001, hi: 16'h0000};
        vecs[2] = '{period: 32'd0,          lo: 16'hC34F, hi: 16'h0000};
        vecs[3] = '{period: 32'd2,          lo: 16'h0001, hi: 16'h0000};
        vecs[4] = '{period: 32'h0001_2345,  lo: 16'h2344, hi: 16'h0001};
        vecs[5] = '{period: 32'hFFFF_FFFF,  lo: 16'hFFFE, hi: 16'hFFFF};
        vecs[6] = '{period: 32'h0001_0001,  lo: 16'h0000, hi: 16'h0001};

        reset = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_period = 32'd0;
        timer_irq = 1'b0; m_readdata = 16'h0000; model_count = 16'h0000;
`ifdef POKEMON_TICK_SNAPSHOT_EN
        cfg_snap = 1'b0; rd_val6 = 16'h1234; rd_val7 = 16'h0000;
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check_bus("reset bus", 1'b0, 1'b1, 4'd0, 16'h0000);
        check("reset busy", 32'(busy), 32'd0);
        check("reset tick", 32'(tick), 32'd0);
        check("reset count", 32'(tick_count), 32'd0);

        for (int i = 0; i < 7; i++) begin
            program_timer($sformatf("vec%0d", i), vecs[i].period, vecs[i].lo, vecs[i].hi, 1'b0);
            stop_timer($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            logic [31:0] p, l;
            p = (i < 2) ? 32'($urandom_range(0, 3)) : $urandom;
            l = exp_load(p);
            program_timer($sformatf("rnd%0d", i), p, l[15:0], l[31:16], 1'b0);
            stop_timer($sformatf("rnd%0d", i));
        end

        // Start/stop pulses while programming must be dropped.
        program_timer("noise", 32'd100, 16'h0063, 16'h0000, 1'b1);
        step();
        check_bus("noise no stop", 1'b0, 1'b1, 4'd0, 16'h0000);
        check("noise busy", 32'(busy), 32'd1);
        cfg_start = 1'b1;
        cfg_period = 32'd7;
        step();
        check_bus("start in run ignored", 1'b0, 1'b1, 4'd0, 16'h0000);

        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 4)) begin
                step();
                check("gap tick", 32'(tick), 32'd0);
            end
            service_irq($sformatf("irq%0d", i));
        end

        // Count wrap at 0xFFFF.
        @(negedge clk);
        force dut.tick_count = 16'hFFFF;
        #1 release dut.tick_count;
        model_count = 16'hFFFF;
        check("preset count", 32'(tick_count), 32'h0000_FFFF);
        service_irq("wrap");
        check("wrap value", 32'(tick_count), 32'd0);

`ifdef POKEMON_TICK_SNAPSHOT_EN
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin
                rd_val6 = 16'($urandom);
                rd_val7 = 16'($urandom);
            end
            cfg_snap = 1'b1;
            step();
            check_bus("snap wr a6", 1'b1, 1'b0, 4'd6, 16'h0000);
            step();
            check_bus("snap rd a6", 1'b1, 1'b1, 4'd6, 16'h0000);
            step();
            check_bus("snap rd a7", 1'b1, 1'b1, 4'd7, 16'h0000);
            step();
            check("snap valid early", 32'(snap_valid), 32'd0);
            timer_irq = 1'b1;
            step();
            check("snap valid", 32'(snap_valid), 32'd1);
            check("snap value", snap_value, {rd_val7, rd_val6});
            step();
            model_count = model_count + 16'd1;
            check("snap valid drop", 32'(snap_valid), 32'd0);
            check("irq after snap", 32'(tick), 32'd1);
            step();
        end
`endif

        // Stop coincident with IRQ: clear first, then stop.
        timer_irq = 1'b1;
        cfg_stop  = 1'b1;
        step();
        model_count = model_count + 16'd1;
        check_bus("stop+irq clr", 1'b1, 1'b0, 4'd0, 16'h0000);
        check("stop+irq tick", 32'(tick), 32'd1);
        check("stop+irq count", 32'(tick_count), 32'(model_count));
        step();
        check_bus("stop+irq run", 1'b0, 1'b1, 4'd0, 16'h0000);
        check("stop+irq busy run", 32'(busy), 32'd1);
        stop_timer("stop+irq");

        // Asynchronous reset in the middle of a status clear.
        program_timer("areset", 32'd0, 16'hC34F, 16'h0000, 1'b0);
        timer_irq = 1'b1;
        step();
        check("areset pre tick", 32'(tick), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_bus("areset bus", 1'b0, 1'b1, 4'd0, 16'h0000);
        check("areset tick", 32'(tick), 32'd0);
        check("areset count", 32'(tick_count), 32'd0);
        check("areset busy", 32'(busy), 32'd0);
        timer_irq = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        program_timer("post reset", 32'd50000, 16'hC34F, 16'h0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
